// File: rtl/mseq_stack.sv
// Microsequencer: eight next-address modes over a register-based return stack,
// driving an external combinational microcode ROM.
module mseq_stack #(
  parameter int OPCODE_WIDTH    = 7,
  parameter int ADDR_WIDTH      = 13,
  parameter int CONTROL_WIDTH   = 34,
  parameter int COND_SEL_WIDTH  = 2,
  parameter int STACK_DEPTH     = 4,
  parameter int INITIAL_ADDRESS = 0,
  localparam int COND_COUNT = 2**COND_SEL_WIDTH,
  localparam int W          = CONTROL_WIDTH + ADDR_WIDTH + COND_SEL_WIDTH + 4,
  localparam int DEPTH_W    = $clog2(STACK_DEPTH + 1)
) (
  input  logic                     clock,
  input  logic                     notReset,
  input  logic                     stall,
  input  logic [OPCODE_WIDTH-1:0]  opcode,
  input  logic [COND_COUNT-1:0]    cond,
  output logic [ADDR_WIDTH-1:0]    rom_addr,
  input  logic [W-1:0]             rom_data,
  output logic [CONTROL_WIDTH-1:0] control,
  output logic [DEPTH_W-1:0]       depth,
  output logic                     err
);

  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] INIT_ADDR = ADDR_WIDTH'(INITIAL_ADDRESS);

  typedef enum logic [2:0] {
    M_NEXT     = 3'd0,
    M_JUMP     = 3'd1,
    M_DISPATCH = 3'd2,
    M_BRANCH   = 3'd3,
    M_CALL     = 3'd4,
    M_RET      = 3'd5,
    M_CALLC    = 3'd6,
    M_WAIT     = 3'd7
  } mode_e;

  mode_e                     mode_s;
  logic                      pol_s;
  logic [COND_SEL_WIDTH-1:0] cond_sel_s;
  logic [ADDR_WIDTH-1:0]     next_addr_s;
  logic                      take_s;
  logic [ADDR_WIDTH-1:0]     upc_inc_s;
  logic [ADDR_WIDTH-1:0]     next_upc_s;
  logic                      push_s;
  logic                      pop_s;
  logic                      underflow_s;
  logic                      overflow_s;
  logic                      full_s;
  logic                      empty_s;
  logic [IDX_W-1:0]          top_idx_s;
  logic [IDX_W-1:0]          push_idx_s;

  logic [ADDR_WIDTH-1:0]     upc_r;
  logic [DEPTH_W-1:0]        depth_r;
  logic                      err_r;
  logic [ADDR_WIDTH-1:0]     stack_r [STACK_DEPTH];

  assign mode_s      = mode_e'(rom_data[2:0]);
  assign pol_s       = rom_data[3];
  assign cond_sel_s  = rom_data[4 +: COND_SEL_WIDTH];
  assign next_addr_s = rom_data[4 + COND_SEL_WIDTH +: ADDR_WIDTH];
  assign control     = rom_data[W-1 -: CONTROL_WIDTH];

  assign take_s     = cond[cond_sel_s] ^ pol_s;
  assign upc_inc_s  = upc_r + ADDR_WIDTH'(1);
  assign full_s     = (depth_r == DEPTH_W'(STACK_DEPTH));
  assign empty_s    = (depth_r == DEPTH_W'(0));
  // Top index wraps when empty; it is only consumed when the stack holds an entry.
  assign top_idx_s  = IDX_W'(depth_r - DEPTH_W'(1));
  assign push_idx_s = IDX_W'(depth_r);
  assign overflow_s = push_s & full_s;

  // Next-address selection and stack intent for the current microword.
  always_comb begin
    next_upc_s  = upc_inc_s;
    push_s      = 1'b0;
    pop_s       = 1'b0;
    underflow_s = 1'b0;
    case (mode_s)
      M_NEXT:     next_upc_s = upc_inc_s;
      M_JUMP:     next_upc_s = next_addr_s;
      M_DISPATCH: next_upc_s = {next_addr_s[ADDR_WIDTH-1:OPCODE_WIDTH], opcode};
      M_BRANCH: begin
        if (take_s) next_upc_s = next_addr_s;
        else        next_upc_s = upc_inc_s;
      end
      M_CALL: begin
        next_upc_s = next_addr_s;
        push_s     = 1'b1;
      end
      M_RET: begin
        if (empty_s) begin
          next_upc_s  = INIT_ADDR;
          underflow_s = 1'b1;
        end else begin
          next_upc_s = stack_r[top_idx_s];
          pop_s      = 1'b1;
        end
      end
      M_CALLC: begin
        if (take_s) begin
          next_upc_s = next_addr_s;
          push_s     = 1'b1;
        end else begin
          next_upc_s = upc_inc_s;
        end
      end
      M_WAIT: begin
        if (take_s) next_upc_s = upc_inc_s;
        else        next_upc_s = upc_r;
      end
      default:    next_upc_s = upc_inc_s;
    endcase
  end

  // Sequencer state: upc, return stack, occupancy and sticky error; all frozen by stall.
  always_ff @(posedge clock or negedge notReset) begin
    if (!notReset) begin
      upc_r   <= INIT_ADDR;
      depth_r <= DEPTH_W'(0);
      err_r   <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) stack_r[i] <= ADDR_WIDTH'(0);
    end else if (!stall) begin
      upc_r <= next_upc_s;
      err_r <= err_r | overflow_s | underflow_s;
      if (push_s && !full_s) begin
        stack_r[push_idx_s] <= upc_inc_s;
        depth_r             <= depth_r + DEPTH_W'(1);
      end else if (pop_s) begin
        depth_r <= depth_r - DEPTH_W'(1);
      end
    end
  end

  assign rom_addr = upc_r;
  assign depth    = depth_r;
  assign err      = err_r;

endmodule

// File: doc/mseq_stack.md
MSEQ_STACK -- requirements
Module: mseq_stack

Interface
REQ-001 Parameter OPCODE_WIDTH, default 7, opcode width.
REQ-002 Parameter ADDR_WIDTH, default 13, microaddress width; SHALL exceed OPCODE_WIDTH.
REQ-003 Parameter CONTROL_WIDTH, default 34, control field width.
REQ-004 Parameter COND_SEL_WIDTH, default 2; condition count COND_COUNT = 2**COND_SEL_WIDTH.
REQ-005 Parameter STACK_DEPTH, default 4, return-stack entries (>=1).
REQ-006 Parameter INITIAL_ADDRESS, default 0, reset and error-recovery microaddress.
REQ-007 Microword width W = CONTROL_WIDTH+ADDR_WIDTH+COND_SEL_WIDTH+4. Fields, LSB first: mode[2:0], polarity[3], cond_sel, next_addr, control.
REQ-008 clock  input  1  sole clock; all state updates on rising edge.
REQ-009 notReset  input  1  asynchronous, active-low reset.
REQ-010 stall  input  1  high = freeze sequencing this cycle.
REQ-011 opcode  input  OPCODE_WIDTH  instruction opcode for dispatch.
REQ-012 cond  input  COND_COUNT  condition flags, e.g. bit0 zero, bit1 carry.
REQ-013 rom_addr  output  ADDR_WIDTH  current microaddress (upc) to external combinational ROM.
REQ-014 rom_data  input  W  microword at rom_addr, same cycle.
REQ-015 control  output  CONTROL_WIDTH  control field of rom_data, combinational pass-through.
REQ-016 depth  output  clog2(STACK_DEPTH+1)  current stack occupancy.
REQ-017 err  output  1  sticky stack error flag.

Function
REQ-018 The block SHALL drive rom_addr from the upc register.
REQ-019 The block SHALL compute c = cond[cond_sel] XOR polarity, where a true c means the condition is taken.
REQ-020 Mode 0 NEXT SHALL set upc to upc+1, with addition modulo 2**ADDR_WIDTH (wrap-around).
REQ-021 Mode 1 JUMP SHALL set upc to next_addr.
REQ-022 Mode 2 DISPATCH SHALL set upc to {next_addr[ADDR_WIDTH-1:OPCODE_WIDTH], opcode}.
REQ-023 Mode 3 BRANCH SHALL set upc to next_addr when c is true, else to upc+1.
REQ-024 Mode 4 CALL SHALL push upc+1 and set upc to next_addr.
REQ-025 Mode 5 RET SHALL pop the top entry into upc.
REQ-026 Mode 6 CALLC SHALL behave as CALL when c is true and as NEXT when c is false.
REQ-027 Mode 7 WAIT SHALL set upc to upc+1 when c is true and hold upc when c is false.
REQ-028 The stack SHALL be LIFO, and depth SHALL increment on push and decrement on pop.
REQ-029 Stack overflow (push with depth==STACK_DEPTH): the push SHALL be dropped, upc SHALL still take next_addr, depth SHALL be unchanged, and err SHALL be set.
REQ-030 Stack underflow (RET with depth==0): upc SHALL become INITIAL_ADDRESS, depth SHALL stay 0, and err SHALL be set.
REQ-031 err SHALL clear only on reset.
REQ-032 While stall is high, upc, stack, depth and err SHALL hold; control SHALL still reflect rom_data.
REQ-033 Latency: a microword presented in cycle N SHALL determine rom_addr in cycle N+1.
REQ-034 A call SHALL take effect in one cycle; a return SHALL take effect in one cycle.
REQ-035 Back-to-back CALL/RET SHALL be legal every cycle.
REQ-036 Stack storage SHALL be registers; unused entries SHALL be don't-care.

Reset
REQ-037 While notReset is low, the block SHALL immediately, asynchronously of clock, force upc=INITIAL_ADDRESS, depth=0 and err=0.
REQ-038 A reset asserted mid-sequence SHALL discard all stack contents and pending state.
REQ-039 On the first rising edge after notReset deasserts, the block SHALL execute the microword at INITIAL_ADDRESS.
REQ-040 control SHALL follow rom_data at INITIAL_ADDRESS while in reset.

Verification
REQ-041 Reset then NEXT x3 from 0 -> rom_addr sequence 0,1,2,3; depth 0; err 0.
REQ-042 At upc 0x1FFF, NEXT -> upc 0x0000 (wrap); with opcode 0x15 and DISPATCH next_addr 0x0080 -> upc 0x0095.
REQ-043 BRANCH with cond_sel=0, polarity=0: cond[0]=1 -> next_addr; cond[0]=0 -> upc+1; polarity=1 -> inverted result.
REQ-044 Nested CALL at 0x10->0x100 then CALL at 0x100->0x200, then RET, RET -> upc 0x101 then 0x11; depth 1,2,1,0.
REQ-045 Five CALLs with STACK_DEPTH=4 -> err=1 after the fifth and depth=4; RET at depth 0 -> upc=INITIAL_ADDRESS and err=1; WAIT with c false for 3 cycles holds upc, then advances when c goes true.
REQ-046 Stall held 2 cycles during CALL -> no push and upc unchanged; notReset pulsed low mid-stall with depth 3 -> upc 0, depth 0, err 0 without a clock edge.
